btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Input-side counterpart to the display/output path: conditions raw push-button inputs before they reach game logic.
- Provides, per button:
  - 2-FF synchronisation,
  - debounce,
  - a debounced level,
  - single-cycle press and release pulses,
  - a press-plus-auto-repeat pulse stream for held movement buttons.
- Sits between the board pins (BtnU/BtnD/BtnL/BtnR and similar) and the game controller. All N_BTN channels are identical and independent.

Parameters:
- N_BTN, 5, number of button channels.
- DEBOUNCE_CYC, 500000, consecutive stable synchronised cycles required to accept a change (5 ms at 100 MHz); must be ≥ 2.
- REPEAT_DELAY, 50000000, cycles from accepted press to first auto-repeat pulse; must be ≥ 2.
- REPEAT_RATE, 15000000, cycles between subsequent auto-repeat pulses; must be ≥ 2.

Ports:
- ClkPort  in  1  system clock; single clock domain for the block.
- Reset  in  1  synchronous, active-high reset.
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  1-cycle pulse on accepted press.
- btn_release  out  N_BTN  1-cycle pulse on accepted release.
- btn_repeat  out  N_BTN  1-cycle pulse on accepted press and on every auto-repeat.

Behaviour:
- Clocking and reset:
  - One clock (ClkPort); reset is synchronous and active-high (Reset).
  - Reset forces, for every channel: sync FFs = 0, state = IDLE, debounce counter = 0, repeat counter = 0.
  - All outputs are 0 in the cycle after a Reset edge.
  - Reset overrides everything, including mid-debounce or mid-repeat.
- Synchronisation: btn_in[i] passes through 2 FFs; s[i] is the second FF output. Only s[i] is used by the FSM.
- Outputs are registered. Pulses are high for exactly one cycle.
- Per-channel FSM (dcnt width = clog2(DEBOUNCE_CYC), rcnt width = clog2(max(REPEAT_DELAY, REPEAT_RATE))):
  - IDLE: level = 0. s=1 → WAIT_PRESS, dcnt = 0.
  - WAIT_PRESS: level = 0.
    - s=0 → IDLE; no pulse.
    - s=1 and dcnt == DEBOUNCE_CYC-1 → HELD; press = 1, repeat = 1, rcnt = 0.
    - Otherwise dcnt++.
  - HELD: level = 1.
    - s=0 → WAIT_RELEASE, dcnt = 0; rcnt holds its value.
    - s=1 → rcnt++. On reaching the threshold: repeat = 1 and rcnt = 0.
    - Threshold is REPEAT_DELAY-1 before the first auto-repeat and REPEAT_RATE-1 after it. A 1-bit first-repeat flag is set at press and cleared at the first auto-repeat.
  - WAIT_RELEASE: level stays 1; no repeat pulses.
    - s=1 → HELD; no pulse; rcnt and the first-repeat flag resume unchanged.
    - s=0 and dcnt == DEBOUNCE_CYC-1 → IDLE; level = 0, release = 1.
    - Otherwise dcnt++.
- Latency:
  - btn_in sampled high at edge k, then stable → btn_press/btn_repeat/btn_level rise after edge k+DEBOUNCE_CYC+2.
  - Release is symmetric: btn_level falls and btn_release pulses after edge k+DEBOUNCE_CYC+2.
- Boundary conditions:
  - A bounce of even one cycle restarts debounce from zero. A glitch shorter than DEBOUNCE_CYC produces no output.
  - press and release are never asserted in the same cycle for one channel.
  - Simultaneous activity on multiple channels is fully independent; no priority.
  - A button held through Reset deassertion is treated as a fresh press after the full debounce time.
  - Counters never wrap: they are cleared on every state entry and at each repeat threshold.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_BTN=5):
- Reset held 3 cycles with btn_in=5'b11111 → all outputs 0 during reset. After deassertion at edge k0, btn_press=5'b11111 after edge k0+6 (one cycle only), and btn_level=5'b11111 from then on.
- btn_in[0] goes high at edge k and stays high → btn_press[0] and btn_repeat[0] after edge k+6. Further btn_repeat[0] pulses after edges k+16, k+19, k+22. btn_release[0] stays 0.
- btn_in[1] high for 3 cycles, then low → no press, level, or repeat on channel 1, ever.
- btn_in[2] pressed and accepted, then low for 2 cycles, high again → btn_level[2] stays 1, no btn_release[2]. Repeat timing shifts only by the cycles spent in WAIT_RELEASE.
- btn_in[3] pressed and accepted, then released at edge m → btn_release[3] after edge m+6 and btn_level[3] falls in the same cycle. No btn_repeat[3] while in WAIT_RELEASE.
- Reset asserted while channel 4 is in HELD with rcnt=7 → outputs 0. After Reset deasserts with btn_in[4] still high, btn_press[4] occurs 6 edges later and the first repeat comes REPEAT_DELAY after that, confirming rcnt was cleared.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce, level, press/release
// pulses and press-plus-auto-repeat pulse stream per channel.
module btn_conditioner #(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 15000000
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYC);
    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCNT_W = $clog2(RMAX);

    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [RCNT_W-1:0] RTHR_FIRST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RTHR_NEXT  = RCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_HELD,
        ST_WAIT_RELEASE
    } state_t;

    logic [N_BTN-1:0] sync_q1;
    logic [N_BTN-1:0] sync_q2;

    // Two-stage synchroniser for the asynchronous pin levels
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t            state;
        logic [DCNT_W-1:0] dcnt;
        logic [RCNT_W-1:0] rcnt;
        logic              first_rpt;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              repeat_q;
        logic              s;
        logic [RCNT_W-1:0] rthr;

        assign s    = sync_q2[i];
        // Long initial delay until the first auto-repeat, then the faster rate
        assign rthr = first_rpt ? RTHR_FIRST : RTHR_NEXT;

        always_ff @(posedge ClkPort) begin
            if (Reset) begin
                state     <= ST_IDLE;
                dcnt      <= '0;
                rcnt      <= '0;
                first_rpt <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        level_q <= 1'b0;
                        if (s) begin
                            state <= ST_WAIT_PRESS;
                            dcnt  <= '0;
                        end
                    end
                    ST_WAIT_PRESS: begin
                        if (!s) begin
                            state <= ST_IDLE;
                        end else if (dcnt == DCNT_LAST) begin
                            state     <= ST_HELD;
                            level_q   <= 1'b1;
                            press_q   <= 1'b1;
                            repeat_q  <= 1'b1;
                            rcnt      <= '0;
                            first_rpt <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DCNT_W'(1);
                        end
                    end
                    ST_HELD: begin
                        // rcnt is kept across a release bounce so repeat timing resumes
                        if (!s) begin
                            state <= ST_WAIT_RELEASE;
                            dcnt  <= '0;
                        end else if (rcnt == rthr) begin
                            repeat_q  <= 1'b1;
                            rcnt      <= '0;
                            first_rpt <= 1'b0;
                        end else begin
                            rcnt <= rcnt + RCNT_W'(1);
                        end
                    end
                    ST_WAIT_RELEASE: begin
                        if (s) begin
                            state <= ST_HELD;
                        end else if (dcnt == DCNT_LAST) begin
                            state     <= ST_IDLE;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DCNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/repeat parameters.
module tb_btn_conditioner;

    localparam int unsigned N_BTN = 5;

    typedef struct packed {
        logic [N_BTN-1:0] level;
        logic [N_BTN-1:0] press;
        logic [N_BTN-1:0] release_p;
        logic [N_BTN-1:0] rpt;
    } obs_t;

    logic             ClkPort;
    logic             Reset;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    int   checks;
    int   failures;
    obs_t exp_q[$];

    btn_conditioner #(
        .N_BTN       (N_BTN),
        .DEBOUNCE_CYC(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3)
    ) dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    // Idle all channels between scenarios
    task automatic apply_reset();
        Reset  = 1'b1;
        btn_in = '0;
        repeat (2) @(posedge ClkPort);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, x, got;
        Reset  = 1'b1;
        btn_in = '1;
        for (int t = 0; t < 3; t++) begin
            e = '0;
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL reset_hold t=%0d got=%h exp=%h", t, got, x);
            end
        end
        Reset = 1'b0;
        for (int t = 0; t < 25; t++) begin
            e           = '0;
            e.level     = (t >= 6) ? '1 : '0;
            e.press     = (t == 6) ? '1 : '0;
            e.rpt       = (t == 6 || t == 16 || t == 19 || t == 22) ? '1 : '0;
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL reset_release_all t=%0d got=%h exp=%h", t, got, x);
            end
        end
    endtask

    task automatic test_hold_repeat();
        obs_t e, x, got;
        apply_reset();
        for (int t = 0; t < 25; t++) begin
            btn_in    = 5'b00001;
            e         = '0;
            e.level[0] = (t >= 6);
            e.press[0] = (t == 6);
            e.rpt[0]   = (t == 6 || t == 16 || t == 19 || t == 22);
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL hold_repeat t=%0d got=%h exp=%h", t, got, x);
            end
        end
    endtask

    task automatic test_glitch();
        obs_t e, x, got;
        apply_reset();
        for (int t = 0; t < 23; t++) begin
            btn_in    = '0;
            btn_in[1] = (t <= 2) || (t >= 10 && t <= 12) || (t >= 14);
            e          = '0;
            e.level[1] = (t >= 20);
            e.press[1] = (t == 20);
            e.rpt[1]   = (t == 20);
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL glitch t=%0d got=%h exp=%h", t, got, x);
            end
        end
    endtask

    task automatic test_reentry();
        obs_t e, x, got;
        apply_reset();
        for (int t = 0; t < 27; t++) begin
            btn_in    = '0;
            btn_in[2] = !(t == 10 || t == 11);
            e          = '0;
            e.level[2] = (t >= 6);
            e.press[2] = (t == 6);
            e.rpt[2]   = (t == 6 || t == 19 || t == 22 || t == 25);
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL reentry t=%0d got=%h exp=%h", t, got, x);
            end
        end
    endtask

    task automatic test_release();
        obs_t e, x, got;
        apply_reset();
        for (int t = 0; t < 25; t++) begin
            btn_in    = '0;
            btn_in[3] = (t < 14);
            e              = '0;
            e.level[3]     = (t >= 6 && t < 20);
            e.press[3]     = (t == 6);
            e.rpt[3]       = (t == 6);
            e.release_p[3] = (t == 20);
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL release t=%0d got=%h exp=%h", t, got, x);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        obs_t e, x, got;
        apply_reset();
        for (int t = 0; t < 35; t++) begin
            btn_in    = 5'b10000;
            Reset     = (t == 14 || t == 15);
            e = '0;
            if (t < 14) begin
                e.level[4] = (t >= 6);
                e.press[4] = (t == 6);
                e.rpt[4]   = (t == 6);
            end else if (t >= 16) begin
                e.level[4] = (t >= 22);
                e.press[4] = (t == 22);
                e.rpt[4]   = (t == 22 || t == 32);
            end
            exp_q.push_back(e);
            @(posedge ClkPort); #1;
            got = {btn_level, btn_press, btn_release, btn_repeat};
            x = exp_q.pop_front();
            checks++;
            if (got !== x) begin
                failures++;
                $display("FAIL reset_mid_hold t=%0d got=%h exp=%h", t, got, x);
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        btn_in   = '0;
        test_reset();
        test_hold_repeat();
        test_glitch();
        test_reentry();
        test_release();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
